// File: rtl/dst_2d_ctrl_pkg.sv
// Shared transform/quant definitions for the 2-D DST sequencer: core widths,
// default pass shifts, controller states and the in-flight tag carried beside the core.
package dst_2d_ctrl_pkg;

    localparam int DST_IN_W       = 19;
    localparam int DST_OUT_W      = 28;
    localparam int FWD_SHIFT1_DEF = 1;
    localparam int FWD_SHIFT2_DEF = 8;
    localparam int INV_SHIFT1_DEF = 7;
    localparam int INV_SHIFT2_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT1 = 2'd2,
        COL   = 2'd3
    } state_t;

    // pass: 0 = row pass (result goes to the transpose buffer), 1 = column pass (result goes out)
    typedef struct packed {
        logic       valid;
        logic       pass;
        logic [1:0] idx;
        logic       inv;
    } tag_t;

endpackage

// File: rtl/tq_round_clip.sv
// Round-half-up arithmetic right shift followed by signed saturation to OUT_W bits.
// The shift amount is chosen per transform direction.
module tq_round_clip #(
    parameter int IN_W      = 28,
    parameter int OUT_W     = 19,
    parameter int SHIFT_FWD = 1,
    parameter int SHIFT_INV = 7
) (
    input  logic                    inv,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W:0] RND_F = (IN_W+1)'(1) << (SHIFT_FWD - 1);
    localparam logic signed [IN_W:0] RND_I = (IN_W+1)'(1) << (SHIFT_INV - 1);
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] shf;

    always_comb begin
        ext = {din[IN_W-1], din};
        if (inv) begin
            shf = (ext + RND_I) >>> SHIFT_INV;
        end else begin
            shf = (ext + RND_F) >>> SHIFT_FWD;
        end
        if (shf > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (shf < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = shf[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dst_2d_ctrl.sv
// Sequences an external 4x4 DST core through row pass, transpose buffer and column pass.
// state | meaning
// IDLE  | ready for row 0 of a new block; direction latched on its handshake
// LOAD  | accepting rows 1..3, each issued to the core as it arrives
// WAIT1 | waiting for the row-3 pass-1 result; issues column 0 when it lands
// COL   | issuing columns 1..3, then back to IDLE
module dst_2d_ctrl
    import dst_2d_ctrl_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int CORE_LAT   = 2,
    parameter int FWD_SHIFT1 = FWD_SHIFT1_DEF,
    parameter int FWD_SHIFT2 = FWD_SHIFT2_DEF,
    parameter int INV_SHIFT1 = INV_SHIFT1_DEF,
    parameter int INV_SHIFT2 = INV_SHIFT2_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_inverse,
    input  logic [4*IN_W-1:0]        in_row,
    output logic                     core_inverse,
    output logic [4*DST_IN_W-1:0]    core_i,
    input  logic [4*DST_OUT_W-1:0]   core_o,
    output logic                     out_valid,
    output logic [4*OUT_W-1:0]       out_row,
    output logic                     out_last,
    output logic                     busy
);

    state_t                     state;
    logic [1:0]                 row_cnt;
    logic [1:0]                 col_cnt;
    logic                       blk_inv;
    logic signed [DST_IN_W-1:0] buf_q [4][4];
    tag_t                       iss_tag;
    tag_t                       tag_p [CORE_LAT];
    tag_t                       res_tag;
    logic                       hs;
    logic                       p1_we;
    logic                       pipe_busy;
    logic [1:0]                 col_sel;
    logic signed [DST_IN_W-1:0] p1_val [4];
    logic signed [OUT_W-1:0]    p2_val [4];
    logic signed [DST_IN_W-1:0] col_data [4];
    logic [4*DST_IN_W-1:0]      iss_data;

    assign hs      = in_valid & in_ready;
    assign res_tag = tag_p[CORE_LAT-1];
    assign p1_we   = res_tag.valid & ~res_tag.pass;
    assign busy    = (state != IDLE) | pipe_busy;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        tq_round_clip #(
            .IN_W(DST_OUT_W), .OUT_W(DST_IN_W),
            .SHIFT_FWD(FWD_SHIFT1), .SHIFT_INV(INV_SHIFT1)
        ) u_p1 (
            .inv(res_tag.inv), .din(core_o[k*DST_OUT_W +: DST_OUT_W]), .dout(p1_val[k])
        );
        tq_round_clip #(
            .IN_W(DST_OUT_W), .OUT_W(OUT_W),
            .SHIFT_FWD(FWD_SHIFT2), .SHIFT_INV(INV_SHIFT2)
        ) u_p2 (
            .inv(res_tag.inv), .din(core_o[k*DST_OUT_W +: DST_OUT_W]), .dout(p2_val[k])
        );
    end

    // Column 0 is issued in the same cycle the row-3 result is written, so that
    // element bypasses the buffer.
    always_comb begin
        col_sel = (state == COL) ? col_cnt : 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (p1_we && res_tag.idx == r[1:0]) begin
                col_data[r] = p1_val[col_sel];
            end else begin
                col_data[r] = buf_q[col_sel][r];
            end
        end
        iss_data = '0;
        for (int n = 0; n < 4; n++) begin
            if (state == IDLE || state == LOAD) begin
                iss_data[n*DST_IN_W +: DST_IN_W] =
                    {{(DST_IN_W-IN_W){in_row[n*IN_W+IN_W-1]}}, in_row[n*IN_W +: IN_W]};
            end else begin
                iss_data[n*DST_IN_W +: DST_IN_W] = col_data[n];
            end
        end
        pipe_busy = iss_tag.valid;
        for (int i = 0; i < CORE_LAT; i++) begin
            pipe_busy = pipe_busy | tag_p[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            row_cnt      <= 2'd0;
            col_cnt      <= 2'd0;
            blk_inv      <= 1'b0;
            in_ready     <= 1'b0;
            core_i       <= '0;
            core_inverse <= 1'b0;
            iss_tag      <= '0;
            out_valid    <= 1'b0;
            out_row      <= '0;
            out_last     <= 1'b0;
            for (int i = 0; i < CORE_LAT; i++) tag_p[i] <= '0;
            for (int k = 0; k < 4; k++) begin
                for (int r = 0; r < 4; r++) buf_q[k][r] <= '0;
            end
        end else begin
            iss_tag      <= '0;
            core_i       <= '0;
            core_inverse <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            tag_p[0]     <= iss_tag;
            for (int i = 1; i < CORE_LAT; i++) tag_p[i] <= tag_p[i-1];

            if (p1_we) begin
                for (int k = 0; k < 4; k++) buf_q[k][res_tag.idx] <= p1_val[k];
            end
            if (res_tag.valid && res_tag.pass) begin
                out_valid <= 1'b1;
                out_last  <= (res_tag.idx == 2'd3);
                for (int k = 0; k < 4; k++) out_row[k*OUT_W +: OUT_W] <= p2_val[k];
            end

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (hs) begin
                        blk_inv      <= in_inverse;
                        core_i       <= iss_data;
                        core_inverse <= in_inverse;
                        iss_tag      <= '{valid: 1'b1, pass: 1'b0, idx: 2'd0, inv: in_inverse};
                        row_cnt      <= 2'd1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        core_i       <= iss_data;
                        core_inverse <= blk_inv;
                        iss_tag      <= '{valid: 1'b1, pass: 1'b0, idx: row_cnt, inv: blk_inv};
                        row_cnt      <= row_cnt + 2'd1;
                        if (row_cnt == 2'd3) begin
                            in_ready <= 1'b0;
                            state    <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (p1_we && res_tag.idx == 2'd3) begin
                        core_i       <= iss_data;
                        core_inverse <= blk_inv;
                        iss_tag      <= '{valid: 1'b1, pass: 1'b1, idx: 2'd0, inv: blk_inv};
                        col_cnt      <= 2'd1;
                        state        <= COL;
                    end
                end
                COL: begin
                    core_i       <= iss_data;
                    core_inverse <= blk_inv;
                    iss_tag      <= '{valid: 1'b1, pass: 1'b1, idx: col_cnt, inv: blk_inv};
                    col_cnt      <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dst_2d_ctrl.sv
// Directed/random bench for dst_2d_ctrl with a two-cycle DST core model and a
// whole-block matrix reference model feeding an expected-row queue.
module tb_dst_2d_ctrl;

    localparam int IN_W  = 16;
    localparam int OUT_W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic          in_inverse;
    logic [63:0]   in_row;
    logic          core_inverse;
    logic [75:0]   core_i;
    logic [111:0]  core_o;
    logic [111:0]  core_s1;
    logic          out_valid;
    logic [63:0]   out_row;
    logic          out_last;
    logic          busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int first_out_cyc = -1;

    typedef struct {
        logic [63:0] row;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    int dm [4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74}, '{84, -29, -74, 55}, '{55, -84, 74, -29}};
    logic signed [15:0] x_in [4][4];
    longint y_m [4][4];
    longint o_m [4][4];

    dst_2d_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inverse(in_inverse), .in_row(in_row), .core_inverse(core_inverse),
        .core_i(core_i), .core_o(core_o), .out_valid(out_valid), .out_row(out_row),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int coef(input int j, input int m, input bit inv);
        return inv ? dm[m][j] : dm[j][m];
    endfunction

    function automatic logic [111:0] core_eval(input logic [75:0] ci, input logic inv);
        logic [111:0] res;
        longint acc;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int m = 0; m < 4; m++)
                acc += longint'(coef(j, m, inv)) * longint'($signed(ci[m*19 +: 19]));
            res[j*28 +: 28] = acc[27:0];
        end
        return res;
    endfunction

    always @(posedge clk) begin
        core_s1 <= core_eval(core_i, core_inverse);
        core_o  <= core_s1;
    end

    function automatic longint rnd(input longint v, input int s);
        return (v + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    function automatic longint clip(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // Rows through the transform, then columns of the intermediate; out row k is column k.
    task automatic compute_block(input bit inv);
        longint acc;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                acc = 0;
                for (int n = 0; n < 4; n++) acc += longint'(coef(k, n, inv)) * longint'(x_in[r][n]);
                y_m[r][k] = clip(rnd(acc, inv ? 7 : 1), 19);
            end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int r = 0; r < 4; r++) acc += longint'(coef(j, r, inv)) * y_m[r][k];
                o_m[k][j] = clip(rnd(acc, inv ? 12 : 8), 16);
            end
    endtask

    function automatic logic [63:0] pack_row(input int k);
        logic [63:0] pr;
        for (int j = 0; j < 4; j++) pr[j*16 +: 16] = 16'(o_m[k][j]);
        return pr;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_out_valid: got out_valid=1 row 0x%0h, expected no pending row", out_row);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_row", out_row, e.row);
                chk("out_last", 64'(out_last), 64'(e.last));
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
        end
    end

    task automatic fill_const(input int v);
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 4; n++) x_in[r][n] = 16'(v);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 4; n++) x_in[r][n] = 16'($urandom);
    endtask

    // Called at a negedge; returns at the negedge right after the 4th handshake.
    task automatic send_rows(input bit inv, input int max_gap, input bit toggle);
        int guard;
        for (int r = 0; r < 4; r++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    in_valid   = 1'b0;
                    in_inverse = toggle ? ~inv : inv;
                    @(negedge clk);
                end
            end
            in_valid   = 1'b1;
            in_inverse = (r == 0 || !toggle) ? inv : ~inv;
            for (int n = 0; n < 4; n++) in_row[n*16 +: 16] = x_in[r][n];
            guard = 0;
            while (!in_ready && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 64) begin
                compared++;
                mismatched++;
                $display("FAIL in_ready_timeout: got in_ready=0 for 64 cycles, expected 1");
            end
            @(negedge clk);
            if (r == 0) hs_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_block(input bit inv, input int max_gap, input bit toggle);
        int n_low;
        compute_block(inv);
        send_rows(inv, max_gap, toggle);
        for (int k = 0; k < 4; k++) exp_q.push_back('{row: pack_row(k), last: (k == 3)});
        n_low = 0;
        while (!in_ready && n_low < 20) begin
            n_low++;
            @(negedge clk);
        end
        chk("in_ready_low_cycles", 64'(n_low), 64'd6);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_rows_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_row"}, out_row, 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_core_i"}, 64'(|core_i), 64'd0);
        chk({tag, "_core_inverse"}, 64'(core_inverse), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        in_valid   = 1'b0;
        in_inverse = 1'b0;
        in_row     = '0;
        #2 rst = 1'b0;
        #10 check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_release", 64'(in_ready), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);

        // Hand-derived values pinning the reference model.
        fill_const(64);
        compute_block(1'b0);
        chk("model_dc_p1_c0", 64'(y_m[0][0]), 64'd7744);
        chk("model_dc_p1_c1", 64'(y_m[1][1]), 64'd2368);
        chk("model_dc_p1_c2", 64'(y_m[2][2]), 64'd1152);
        chk("model_dc_p1_c3", 64'(y_m[3][3]), 64'd512);
        chk("model_dc_o00", 64'(o_m[0][0]), 64'd7321);
        chk("model_dc_row0", pack_row(0), 64'h01E4_0441_08BF_1C99);
        fill_const(32767);
        compute_block(1'b0);
        chk("model_sat_row0", pack_row(0), 64'h4000_7FFF_7FFF_7FFF);
        fill_const(0);
        x_in[0][0] = 16'sd64;
        compute_block(1'b1);
        chk("model_inv_p1_0", 64'(y_m[0][0]), 64'd15);
        chk("model_inv_p1_2", 64'(y_m[0][2]), 64'd37);
        chk("model_inv_p1_3", 64'(y_m[0][3]), 64'd42);

        @(negedge clk);
        fill_const(0);
        first_out_cyc = -1;
        send_block(1'b0, 0, 1'b0);
        drain();
        chk("first_out_latency", 64'(first_out_cyc - hs_cyc), 64'd9);

        fill_const(64);     send_block(1'b0, 0, 1'b0);
        fill_const(32767);  send_block(1'b0, 0, 1'b0);
        fill_const(-32768); send_block(1'b0, 0, 1'b0);
        repeat (20) begin fill_rand(); send_block(1'b0, 0, 1'b0); end
        fill_const(32767);  send_block(1'b1, 0, 1'b0);
        fill_const(-32768); send_block(1'b1, 0, 1'b0);
        repeat (200) begin fill_rand(); send_block(1'b1, 0, 1'b0); end
        repeat (12) begin fill_rand(); send_block(1'($urandom_range(0, 1)), 3, 1'b1); end
        fill_rand(); send_block(1'b0, 0, 1'b0);
        fill_rand(); send_block(1'b1, 0, 1'b0);
        drain();

        // Abort a block while it waits for its row-pass results.
        fill_rand();
        send_rows(1'b0, 0, 1'b0);
        chk("busy_in_wait1", 64'(busy), 64'd1);
        chk("ready_low_wait1", 64'(in_ready), 64'd0);
        #1 rst = 1'b0;
        #1 check_outputs_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_mid_release", 64'(in_ready), 64'd1);
        repeat (15) @(negedge clk);
        fill_rand(); send_block(1'b0, 0, 1'b0);
        fill_rand(); send_block(1'b1, 2, 1'b1);
        drain();
        repeat (5) @(negedge clk);
        chk("busy_after_drain", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
